spi_slave_oversampled: RTL

Parametrised SPI slave that runs entirely in the FPGA clock domain. SCLK, MOSI and CS_n are oversampled through synchronisers, not used as clocks. Word width, SPI mode and bit order are set by parameters. Outgoing words are buffered in a TX FIFO so the host can queue multiple words per CS_n transaction. The block sits between the board SPI pins and the fabric register/command logic, as the single-clock successor of the byte-wide SPI slave.

---
 rtl/spi_slave_oversampled.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_oversampled.sv
// SPI slave running entirely on i_Clk. SCLK, MOSI and CS_n are oversampled
// through synchronisers. Outgoing words come from a small TX FIFO so the host
// can queue several words for one CS_n transaction.
//
// state       | meaning
// ST_SETTLE   | after reset, waiting for the CS_n synchroniser to hold real pin data
// ST_DISARMED | ignoring CS_n until it has been seen high
// ST_ARMED    | CS_n edges and SCLK edges are acted on
module spi_slave_oversampled #(
   parameter int SPI_MODE      = 0,
   parameter int WORD_WIDTH    = 8,
   parameter int TX_FIFO_DEPTH = 4,
   parameter int LSB_FIRST     = 0
) (
   input  logic                                   i_Clk,
   input  logic                                   i_Rst,
   output logic                                   o_RX_DV,
   output logic [WORD_WIDTH-1:0]                  o_RX_Word,
   output logic                                   o_RX_Abort,
   input  logic                                   i_TX_DV,
   input  logic [WORD_WIDTH-1:0]                  i_TX_Word,
   output logic                                   o_TX_Ready,
   output logic [$clog2(TX_FIFO_DEPTH+1)-1:0]     o_TX_Count,
   output logic                                   o_TX_Underrun,
   output logic                                   o_CS_Active,
   input  logic                                   i_SPI_Clk,
   input  logic                                   i_SPI_MOSI,
   input  logic                                   i_SPI_CS_n,
   output logic                                   o_SPI_MISO
);

   localparam bit CPOL = (SPI_MODE & 2) != 0;
   localparam bit CPHA = (SPI_MODE & 1) != 0;
   localparam bit LSB  = LSB_FIRST != 0;
   localparam int BW   = $clog2(WORD_WIDTH);
   localparam int AW   = $clog2(TX_FIFO_DEPTH);
   localparam int CW   = $clog2(TX_FIFO_DEPTH+1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH-1);
   localparam logic [CW-1:0] FULL_CNT = CW'(TX_FIFO_DEPTH);

   typedef enum logic [1:0] {ST_SETTLE, ST_DISARMED, ST_ARMED} arm_state_t;

   arm_state_t            arm_state;
   logic [1:0]            settle_cnt;
   logic [2:0]            sclk_s;
   logic [2:0]            cs_s;
   logic [1:0]            mosi_s;
   logic                  armed;
   logic                  active;
   logic                  lead_edge;
   logic                  trail_edge;
   logic                  sample_edge;
   logic                  shift_edge;
   logic                  cs_fall;
   logic                  cs_rise;
   logic                  tx_load;
   logic [BW-1:0]         rx_cnt;
   logic [WORD_WIDTH-1:0] rx_shift;
   logic [WORD_WIDTH-1:0] rx_next;
   logic [WORD_WIDTH-1:0] tx_shift;
   logic [WORD_WIDTH-1:0] fifo_mem [TX_FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_next;
   logic                  fifo_empty;
   logic                  wr;
   logic                  pop;
   logic                  miso_bit;

   // Bring the SPI pins into the i_Clk domain; 3rd stage on SCLK/CS_n for edges.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sclk_s <= {3{CPOL}};
         cs_s   <= 3'b111;
         mosi_s <= 2'b00;
      end else begin
         sclk_s <= {sclk_s[1:0], i_SPI_Clk};
         cs_s   <= {cs_s[1:0], i_SPI_CS_n};
         mosi_s <= {mosi_s[0], i_SPI_MOSI};
      end
   end

   // Arming: the synchroniser resets to "CS_n high", so wait for it to flush
   // before trusting a high level, otherwise a reset taken mid-transaction
   // would look like a fresh CS_n fall.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         arm_state  <= ST_SETTLE;
         settle_cnt <= 2'd3;
      end else begin
         case (arm_state)
            ST_SETTLE: begin
               if (settle_cnt == 2'd0) arm_state <= ST_DISARMED;
               else                    settle_cnt <= settle_cnt - 2'd1;
            end
            ST_DISARMED: if (cs_s[1]) arm_state <= ST_ARMED;
            ST_ARMED:    arm_state <= ST_ARMED;
            default:     arm_state <= ST_SETTLE;
         endcase
      end
   end

   assign armed       = (arm_state == ST_ARMED);
   assign active      = armed & ~cs_s[1];
   assign o_CS_Active = active;
   assign lead_edge   = CPOL ? (~sclk_s[1] & sclk_s[2]) : (sclk_s[1] & ~sclk_s[2]);
   assign trail_edge  = CPOL ? (sclk_s[1] & ~sclk_s[2]) : (~sclk_s[1] & sclk_s[2]);
   assign sample_edge = active & (CPHA ? trail_edge : lead_edge);
   assign shift_edge  = active & (CPHA ? lead_edge : trail_edge);
   assign cs_fall     = armed & ~cs_s[1] & cs_s[2];
   assign cs_rise     = armed & cs_s[1] & ~cs_s[2];
   // A shift edge seen with the bit count at 0 always starts a new word:
   // for CPHA=0 the first edge of a transaction is a sample edge, so this
   // only fires after a completed word.
   assign tx_load     = (!CPHA && cs_fall) || (shift_edge && (rx_cnt == '0));

   // Next RX shift register value for the incoming MOSI bit.
   always_comb begin
      rx_next = LSB ? {mosi_s[1], rx_shift[WORD_WIDTH-1:1]}
                    : {rx_shift[WORD_WIDTH-2:0], mosi_s[1]};
   end

   // RX: collect bits, publish full words, flag words cut short by CS_n.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         rx_shift   <= '0;
         rx_cnt     <= '0;
         o_RX_Word  <= '0;
         o_RX_DV    <= 1'b0;
         o_RX_Abort <= 1'b0;
      end else begin
         o_RX_DV    <= 1'b0;
         o_RX_Abort <= 1'b0;
         if (cs_rise) begin
            rx_cnt <= '0;
            if (rx_cnt != '0) o_RX_Abort <= 1'b1;
         end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (rx_cnt == LAST_BIT) begin
               o_RX_Word <= rx_next;
               o_RX_DV   <= 1'b1;
               rx_cnt    <= '0;
            end else begin
               rx_cnt <= rx_cnt + BW'(1);
            end
         end
      end
   end

   // TX: load from the FIFO head (zeros on underrun) or advance one bit.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         tx_shift      <= '0;
         o_TX_Underrun <= 1'b0;
      end else begin
         o_TX_Underrun <= 1'b0;
         if (cs_rise) begin
            tx_shift <= '0;
         end else if (tx_load) begin
            tx_shift      <= fifo_empty ? '0 : fifo_mem[rd_ptr];
            o_TX_Underrun <= fifo_empty;
         end else if (shift_edge) begin
            tx_shift <= LSB ? (tx_shift >> 1) : (tx_shift << 1);
         end
      end
   end

   assign miso_bit   = LSB ? tx_shift[0] : tx_shift[WORD_WIDTH-1];
   assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : miso_bit;

   assign fifo_empty = (o_TX_Count == '0);
   assign wr         = i_TX_DV & o_TX_Ready;
   assign pop        = tx_load & ~fifo_empty;

   always_comb begin
      count_next = o_TX_Count + CW'(wr) - CW'(pop);
   end

   // FIFO storage.
   always_ff @(posedge i_Clk) begin
      if (wr) fifo_mem[wr_ptr] <= i_TX_Word;
   end

   // FIFO pointers, occupancy and registered ready.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_TX_Count <= '0;
         o_TX_Ready <= 1'b1;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         o_TX_Count <= count_next;
         o_TX_Ready <= (count_next != FULL_CNT);
      end
   end

endmodule
